// File: rtl/sp_frame_scheduler.sv
// sp_frame_scheduler: round-robin frame buffer and result router in front of one SP instance.
// Define SP_SCHED_CG_EN to drive sp_cg_en high while SP is idle (IDLE, LOAD, GAP).
module sp_frame_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [8:0]        req_data0,
    input  logic [8:0]        req_data1,
    input  logic [2:0]        req_mode0,
    input  logic [2:0]        req_mode1,
    output logic              sp_in_valid,
    output logic [8:0]        sp_in_data,
    output logic [2:0]        sp_in_mode,
    output logic              sp_cg_en,
    input  logic              sp_out_valid,
    input  logic signed [9:0] sp_out_data,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [1:0]        rsp_idx,
    output logic signed [9:0] rsp_data,
    output logic              err_timeout,
    output logic              busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAKE, SEND, WAIT, GAP} state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d, gnt_q, gnt_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [8:0]        buf_q [9];
    logic [8:0]        buf_d [9];
    logic [2:0]        mode_q, mode_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [1:0]        beat_q, beat_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              rsp_valid_q, rsp_id_q;
    logic [1:0]        rsp_idx_q;
    logic signed [9:0] rsp_data_q;
    logic              hs, expired, sp_beat;

    assign hs          = state_q == LOAD && req_valid[gnt_q];
    assign expired     = state_q == WAIT && tmo_q == TMO_MAX;
    // A beat landing on the expiry cycle is dropped together with the frame.
    assign sp_beat     = state_q == WAIT && sp_out_valid && !expired;
    assign req_ready   = state_q == LOAD ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign sp_in_valid = state_q == SEND;
    assign sp_in_data  = sp_in_valid ? buf_q[cnt_q] : 9'd0;
    assign sp_in_mode  = sp_in_valid ? mode_q : 3'd0;
    assign err_timeout = expired;
    assign busy        = state_q != IDLE;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_idx     = rsp_idx_q;
    assign rsp_data    = rsp_data_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        tmo_d   = '0;
        beat_d  = '0;
        gap_d   = '0;
        unique case (state_q)
            IDLE: if (|req_valid) begin
                gnt_d   = &req_valid ? ptr_q : req_valid[1];
                ptr_d   = ~gnt_d;
                cnt_d   = 4'd0;
                state_d = LOAD;
            end
            LOAD: if (hs) begin
                buf_d[cnt_q] = gnt_q ? req_data1 : req_data0;
                mode_d       = cnt_q == 4'd0 ? (gnt_q ? req_mode1 : req_mode0) : mode_q;
                cnt_d        = cnt_q == 4'd8 ? 4'd0 : cnt_q + 4'd1;
                state_d      = cnt_q == 4'd8 ? WAKE : LOAD;
            end
            WAKE: state_d = SEND;
            SEND: begin
                cnt_d   = cnt_q == 4'd8 ? 4'd0 : cnt_q + 4'd1;
                state_d = cnt_q == 4'd8 ? WAIT : SEND;
            end
            WAIT: begin
                tmo_d   = sp_out_valid ? '0 : tmo_q + TW'(1);
                beat_d  = beat_q + {1'b0, sp_out_valid};
                state_d = expired || (sp_out_valid && beat_q == 2'd2) ? GAP : WAIT;
            end
            GAP: begin
                gap_d   = gap_q + GW'(1);
                state_d = gap_q == GAP_LAST ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            gnt_q       <= 1'b0;
            cnt_q       <= '0;
            buf_q       <= '{default: '0};
            mode_q      <= '0;
            tmo_q       <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            mode_q      <= mode_d;
            tmo_q       <= tmo_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            rsp_valid_q <= sp_beat;
            if (sp_beat) begin
                rsp_id_q   <= gnt_q;
                rsp_idx_q  <= beat_q;
                rsp_data_q <= sp_out_data;
            end
        end
    end

`ifdef SP_SCHED_CG_EN
    logic cg_q;
    always_ff @(posedge clk) begin
        if (rst) cg_q <= 1'b1;
        else     cg_q <= state_d inside {IDLE, LOAD, GAP};
    end
    assign sp_cg_en = cg_q;
`else
    assign sp_cg_en = 1'b0;
`endif
endmodule

// File: tb/tb_sp_frame_scheduler.sv
// tb_sp_frame_scheduler: directed frame table plus reset/timeout sequences for sp_frame_scheduler.
module tb_sp_frame_scheduler;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [8:0]        req_data0 = '0, req_data1 = '0;
    logic [2:0]        req_mode0 = '0, req_mode1 = '0;
    logic              sp_in_valid;
    logic [8:0]        sp_in_data;
    logic [2:0]        sp_in_mode;
    logic              sp_cg_en;
    logic              sp_out_valid = 1'b0;
    logic signed [9:0] sp_out_data = '0;
    logic              rsp_valid, rsp_id;
    logic [1:0]        rsp_idx;
    logic signed [9:0] rsp_data;
    logic              err_timeout, busy;

`ifdef SP_SCHED_CG_EN
    localparam bit CG_ON = 1'b1;
`else
    localparam bit CG_ON = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sp_frame_scheduler #(.TIMEOUT(8), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_mode0(req_mode0), .req_mode1(req_mode1),
        .sp_in_valid(sp_in_valid), .sp_in_data(sp_in_data), .sp_in_mode(sp_in_mode),
        .sp_cg_en(sp_cg_en),
        .sp_out_valid(sp_out_valid), .sp_out_data(sp_out_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_idx(rsp_idx), .rsp_data(rsp_data),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] valid;
        bit         id;
        int         base;
        logic [2:0] mode;
        int         stall_at;
        int         stall_len;
        int         nbeats;
        logic [9:0] beat [3];
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mk(input logic [1:0] valid, input bit id, input int base,
                                input logic [2:0] mode, input int stall_at, input int stall_len,
                                input int nb, input logic [9:0] b0, input logic [9:0] b1,
                                input logic [9:0] b2);
        vec_t v;
        v.valid = valid; v.id = id; v.base = base; v.mode = mode;
        v.stall_at = stall_at; v.stall_len = stall_len; v.nbeats = nb;
        v.beat[0] = b0; v.beat[1] = b1; v.beat[2] = b2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit id, input logic [8:0] d, input logic [2:0] m);
        if (id) begin req_data1 = d; req_mode1 = m; end
        else    begin req_data0 = d; req_mode0 = m; end
    endtask

    // Starts at an IDLE negedge, returns at the WAKE negedge.
    task automatic load_frame(input vec_t v);
        int k = 0, s = 0, cyc = 0;
        bit hs, other_bad = 0;
        req_valid = v.valid;
        drive(v.id, 9'(v.base), v.mode);
        drive(!v.id, 9'h155, ~v.mode);
        @(negedge clk);
        chk("ready_first", {sp_cg_en, req_ready}, {CG_ON, (v.id ? 2'b10 : 2'b01)});
        while (k < 9 && cyc < 60) begin
            if (k == v.stall_at && s < v.stall_len) begin
                req_valid[v.id] = 1'b0;
                s++;
            end else begin
                req_valid[v.id] = 1'b1;
                drive(v.id, 9'(v.base + k), k == 0 ? v.mode : ~v.mode);
            end
            hs = req_valid[v.id] & req_ready[v.id];
            if (req_ready[!v.id]) other_bad = 1;
            @(negedge clk);
            cyc++;
            if (hs) k++;
        end
        chk("load_count", k, 9);
        chk("other_ready", other_bad, 0);
        req_valid = v.valid;
    endtask

    task automatic send_frame(input vec_t v, output bit hold_bad);
        hold_bad = 0;
        chk("wake", {sp_in_valid, sp_cg_en, busy}, {1'b0, 1'b0, 1'b1});
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (req_ready != 2'b00) hold_bad = 1;
            chk("send_beat", {sp_in_valid, sp_cg_en, sp_in_mode, sp_in_data},
                {1'b1, 1'b0, v.mode, 9'(v.base + j)});
        end
        @(negedge clk);
        chk("send_end", sp_in_valid, 0);
    endtask

    // Starts at an IDLE negedge, returns at the next IDLE negedge.
    task automatic run_frame(input vec_t v);
        bit hold_bad, err_bad = 0;
        load_frame(v);
        send_frame(v, hold_bad);
        @(negedge clk);
        for (int b = 0; b < v.nbeats; b++) begin
            sp_out_valid = 1'b1;
            sp_out_data  = v.beat[b];
            @(negedge clk);
            if (req_ready != 2'b00) hold_bad = 1;
            chk("rsp_beat", {rsp_valid, rsp_id, rsp_idx, rsp_data, err_timeout},
                {1'b1, v.id, 2'(b), v.beat[b], 1'b0});
        end
        sp_out_valid = 1'b0;
        if (v.nbeats == 3) begin
            chk("gap_cg", {sp_cg_en, busy}, {CG_ON, 1'b1});
            sp_out_valid = 1'b1;
            sp_out_data  = 10'h2AA;
            @(negedge clk);
            chk("stray_beat", {rsp_valid, err_timeout, busy}, {1'b0, 1'b0, 1'b1});
            sp_out_valid = 1'b0;
        end else begin
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (c < 8 && err_timeout) err_bad = 1;
            end
            chk("timeout_pulse", {err_timeout, rsp_valid}, {1'b1, 1'b0});
            chk("timeout_early", err_bad, 0);
            @(negedge clk);
            chk("timeout_gap", {err_timeout, busy, sp_cg_en}, {1'b0, 1'b1, CG_ON});
            @(negedge clk);
        end
        chk("holdoff", hold_bad, 0);
        @(negedge clk);
        chk("idle", {busy, req_ready}, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rsp_seen = 0;
        tbl[0] = mk(2'b01, 0,   1, 3'b000, -1, 0, 3, 10'd9,   10'd5,   10'd1);
        tbl[1] = mk(2'b10, 1, 100, 3'b110,  4, 5, 3, 10'd108, 10'd104, 10'd100);
        tbl[2] = mk(2'b01, 0, 200, 3'b011, -1, 0, 1, 10'h3F6, 10'd0,   10'd0);
        tbl[3] = mk(2'b10, 1, 300, 3'b001, -1, 0, 3, 10'h1FF, 10'h000, 10'h200);
        tbl[4] = mk(2'b11, 0,  20, 3'b101, -1, 0, 3, 10'd28,  10'd24,  10'd20);
        tbl[5] = mk(2'b11, 1,  40, 3'b010, -1, 0, 3, 10'd48,  10'd44,  10'd40);
        tbl[6] = mk(2'b11, 0,  60, 3'b111, -1, 0, 3, 10'd68,  10'd64,  10'd60);
        tbl[7] = mk(2'b11, 1,  80, 3'b100, -1, 0, 3, 10'd88,  10'd84,  10'd80);

        repeat (2) @(negedge clk);
        chk("reset_state", {req_ready, sp_in_valid, sp_in_data, sp_in_mode, rsp_valid, rsp_id,
                            rsp_idx, rsp_data, err_timeout, busy, sp_cg_en}, {31'd0, CG_ON});
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_frame(tbl[i]);

        load_frame(mk(2'b01, 0, 400, 3'b100, -1, 0, 3, 10'd0, 10'd0, 10'd0));
        repeat (5) @(negedge clk);
        chk("midsend_beat4", {sp_in_valid, sp_in_data}, {1'b1, 9'd404});
        rst = 1'b1;
        sp_out_valid = 1'b1;
        @(negedge clk);
        chk("midsend_reset", {req_ready, sp_in_valid, sp_in_data, sp_in_mode, rsp_valid, rsp_id,
                              rsp_idx, rsp_data, err_timeout, busy, sp_cg_en}, {31'd0, CG_ON});
        rst = 1'b0;
        req_valid = 2'b00;
        for (int c = 0; c < 12; c++) begin
            sp_out_valid = c[0];
            @(negedge clk);
            if (rsp_valid || busy) rsp_seen = 1;
        end
        sp_out_valid = 1'b0;
        chk("no_rsp_after_reset", rsp_seen, 0);

        for (int i = 4; i < 8; i++) run_frame(tbl[i]);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        chk("final_idle", {busy, sp_cg_en}, {1'b0, CG_ON});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sp_frame_scheduler.md
# sp_frame_scheduler

Two-requester front-end scheduler for the SP sorting/processing datapath. Round-robin arbitrates whole 9-sample frames from two requesters and buffers the granted frame, so that SP receives the 9 contiguous `in_valid` beats it requires. Routes SP's three result beats (max, median, min) back to the owning requester, and drives SP's clock-gating enable while SP is idle. Sits between the two producer streams and a single SP instance.

## Interface
- `TIMEOUT`, 64: max cycles allowed in WAIT without an `sp_out_valid` beat before the frame is abandoned.
- `GAP_CYC`, 2: idle cycles after each frame so SP returns to STANDBY before the next frame starts.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester sample valid (bit i = requester i).
- `req_ready`  out  2  per-requester sample ready; at most one bit high.
- `req_data0`, `req_data1`  in  9  sample data per requester.
- `req_mode0`, `req_mode1`  in  3  frame mode per requester; sampled with the first sample of a frame.
- `sp_in_valid`  out  1  to SP `in_valid`.
- `sp_in_data`  out  9  to SP `in_data`.
- `sp_in_mode`  out  3  to SP `in_mode`.
- `sp_cg_en`  out  1  to SP `cg_en`.
- `sp_out_valid`  in  1  from SP `out_valid`.
- `sp_out_data`  in  10  from SP `out_data`, signed.
- `rsp_valid`  out  1  result beat valid. No backpressure.
- `rsp_id`  out  1  requester that owns the beat.
- `rsp_idx`  out  2  beat index: 0 = max, 1 = median, 2 = min.
- `rsp_data`  out  10  signed result.
- `err_timeout`  out  1  one-cycle pulse when a frame is abandoned.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, WAKE, SEND, WAIT, GAP.
- IDLE:
  - If any `req_valid` bit is set, grant one requester and go to LOAD.
  - When only one requester is valid, it is granted.
  - When both are valid, the round-robin pointer picks the winner.
  - The pointer flips to the other requester after each grant.
  - Pointer reset value: requester 0.
- LOAD:
  - `req_ready[gnt]` is high.
  - Each handshake (`req_valid[gnt] & req_ready[gnt]`) writes the sample into buffer slot `cnt`, and `cnt` increments.
  - `req_mode` is captured on the `cnt == 0` handshake.
  - Stalls (`req_valid` low) are allowed and cost no state.
  - After the 9th handshake (`cnt == 8`), go to WAKE.
  - The other requester's `req_ready` stays 0 throughout.
- WAKE: one cycle, no SP activity; then SEND.
- SEND:
  - 9 consecutive cycles with `sp_in_valid = 1` and `sp_in_data = buffer[k]`, k = 0..8.
  - `sp_in_mode` holds the captured mode for all 9 cycles.
  - Then go to WAIT.
- WAIT:
  - Each `sp_out_valid` beat is forwarded as a registered `rsp_*` beat carrying the owner id and `rsp_idx` = beat count (0, 1, 2).
  - After the 3rd beat, go to GAP.
  - A beat counter tracks the 3 beats; a timeout counter of width `$clog2(TIMEOUT+1)` clears on WAIT entry and on each beat.
  - If the timeout counter reaches `TIMEOUT`, pulse `err_timeout` and go to GAP; beats not yet delivered are dropped.
- GAP: `GAP_CYC` cycles, then IDLE.
- `sp_out_valid` outside WAIT is ignored: no `rsp_valid`, no error.
- `sp_out_data` is passed through unmodified at full 10-bit signed width.

## Timing
- Reset (`rst` high at a rising edge) puts every output at 0 on the next cycle:
  - `req_ready`, `sp_in_valid`, `sp_in_data`, `sp_in_mode`, `rsp_*`, `err_timeout` and `busy` are 0.
  - `sp_cg_en` is 0, or 1 under `SP_SCHED_CG_EN`.
- Reset also forces IDLE and clears the buffer, counters and pointer. Reset in the middle of a frame aborts it with no response.
- `req_ready` is asserted in the first LOAD cycle, one cycle after the `req_valid` that won the grant.
- Last LOAD handshake at edge E: WAKE is cycle E+1, and `sp_in_valid` is high for cycles E+2 through E+10.
- `rsp_valid` is high exactly one cycle after each `sp_out_valid` cycle.
- Minimum frame period with an ideal requester: 1 (IDLE) + 9 (LOAD) + 1 (WAKE) + 9 (SEND) + SP latency + `GAP_CYC`.
- Simultaneous events:
  - A new `req_valid` during LOAD through GAP is held off: `req_ready` stays 0.
  - The final GAP cycle goes to IDLE, never straight to LOAD.

## Configuration
- `SP_SCHED_CG_EN` defined:
  - `sp_cg_en` is registered and equals 1 in IDLE, LOAD and GAP; 0 in WAKE, SEND and WAIT.
  - WAKE therefore gives SP one ungated cycle before data arrives.
- `SP_SCHED_CG_EN` undefined:
  - `sp_cg_en` is tied to 0.
  - The WAKE state is retained, so cycle timing is identical in both builds.

## Test plan
- Single frame: requester 0 sends samples 1..9 with mode 3'b000 and no stalls -> `sp_in_valid` runs 9 cycles with data 1..9 starting 2 cycles after the last handshake; the SP model returns 9, 5, 1 -> `rsp` beats (id 0, idx 0/1/2, data 9/5/1).
- Contention: both `req_valid` high from reset -> requester 0 served first, then requester 1; with both held continuously, grants alternate 0, 1, 0, 1 over 4 frames.
- Stalled load: requester 1 deasserts `req_valid` for 5 cycles after sample 4 -> SEND still presents 9 contiguous beats in the original order, and the captured mode is unchanged.
- Timeout (`TIMEOUT` = 8): the SP model returns only 1 beat -> `err_timeout` pulses 8 cycles after that beat, then after `GAP_CYC` cycles `busy` falls and the next frame is accepted.
- Reset mid-SEND: `rst` asserted at SEND beat 4 -> all outputs 0 next cycle, no `rsp_valid` for that frame, round-robin pointer back at requester 0.
- Clock gating: with `SP_SCHED_CG_EN`, `sp_cg_en` = 1 in IDLE, drops at WAKE and returns to 1 in GAP; without it, `sp_cg_en` stays 0 throughout.
